// File: rtl/btn_debounce_pkg.sv
// Shared debounce definitions: FSM state encodings and default timing constants
// for a 50 MHz board clock.
package debounce_defs;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } db_state_e;

    // 20 ms qualification window at 50 MHz
    localparam int STABLE_CYCLES_DEF = 1_000_000;
    localparam int CNT_W_DEF         = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronises btn, qualifies each level change over
// STABLE_CYCLES clocks and emits the clean level with one-cycle edge pulses.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_ZERO  | accepted level is 0, watching for s2 = 1
// ST_WAIT1 | s2 = 1 seen, counting stable cycles before accepting 1
// ST_ONE   | accepted level is 1, watching for s2 = 0
// ST_WAIT0 | s2 = 0 seen, counting stable cycles before accepting 0
module btn_debounce
    import debounce_defs::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    db_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             db_nxt, rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (s2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ZERO;
            cnt        <= '0;
            db_level   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            db_level   <= db_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db_level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_ZERO: begin
                if (s2) begin
                    state_nxt = ST_WAIT1;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT1: begin
                if (!s2) begin
                    state_nxt = ST_ZERO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_ONE;
                    cnt_nxt   = '0;
                    db_nxt    = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ONE: begin
                if (!s2) begin
                    state_nxt = ST_WAIT0;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT0: begin
                if (s2) begin
                    state_nxt = ST_ONE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_ZERO;
                    cnt_nxt   = '0;
                    db_nxt    = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ZERO;
                cnt_nxt   = '0;
                db_nxt    = 1'b0;
            end
        endcase
    end

endmodule
